// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite motion engine: FSM states, mode
// encodings and the per-axis edge clamp used by both motion modes.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } sprite_state_t;

  localparam logic MODE_BOUNCE  = 1'b0;
  localparam logic MODE_GRAVITY = 1'b1;

  typedef struct packed {
    logic signed [31:0] pos;
    logic               hit_lo;
    logic               hit_hi;
  } clamp_t;

  // Pins a signed candidate position into [lo, hi]; the low bound wins on a tie.
  function automatic clamp_t clamp_axis(input logic signed [31:0] pos_n,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
    clamp_t r;
    r.pos    = pos_n;
    r.hit_lo = 1'b0;
    r.hit_hi = 1'b0;
    if (pos_n <= lo) begin
      r.pos    = lo;
      r.hit_lo = 1'b1;
    end else if (pos_n >= hi) begin
      r.pos    = hi;
      r.hit_hi = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_mover_if.sv
// Control and geometry bundle between the sprite engine and its neighbours.
interface sprite_mover_if #(
  parameter int CW = 12
);
  logic          i_ani_stb;
  logic          i_animate;
  logic          i_mode;
  logic          i_flap;
  logic          i_restart;
  logic [CW-1:0] o_x1;
  logic [CW-1:0] o_x2;
  logic [CW-1:0] o_y1;
  logic [CW-1:0] o_y2;
  logic [1:0]    o_state;
  logic          o_bounce;
  logic          o_dead;

  modport master (
    output i_ani_stb, i_animate, i_mode, i_flap, i_restart,
    input  o_x1, o_x2, o_y1, o_y2, o_state, o_bounce, o_dead
  );

  modport slave (
    input  i_ani_stb, i_animate, i_mode, i_flap, i_restart,
    output o_x1, o_x2, o_y1, o_y2, o_state, o_bounce, o_dead
  );
endinterface

// File: rtl/sprite_mover_axis_step.sv
// One axis of BOUNCE motion: step by STEP in the current direction, clamp to
// the visible range and reflect the direction on contact.
module axis_step
  import sprite_pkg::*;
#(
  parameter int CW     = 12,
  parameter int HALF   = 16,
  parameter int D_SIZE = 640,
  parameter int STEP   = 2
) (
  input  logic [CW-1:0] pos,
  input  logic          dir,
  output logic [CW-1:0] pos_n,
  output logic          dir_n,
  output logic          hit
);
  localparam int                 LO     = HALF;
  localparam int                 HI     = D_SIZE - 1 - HALF;
  localparam logic signed [CW:0] STEP_W = STEP[CW:0];

  logic signed [CW:0] stepped;
  clamp_t             c;

  // One extra signed bit lets a step below zero be seen as a low-edge hit.
  always_comb begin
    stepped = dir ? ($signed({1'b0, pos}) + STEP_W)
                  : ($signed({1'b0, pos}) - STEP_W);
    c       = clamp_axis(32'(stepped), LO, HI);
    pos_n   = CW'(c.pos);
    hit     = c.hit_lo | c.hit_hi;
    if (c.hit_lo)      dir_n = 1'b1;
    else if (c.hit_hi) dir_n = 1'b0;
    else               dir_n = dir;
  end

endmodule

// File: rtl/sprite_mover.sv
// Per-frame sprite motion engine: BOUNCE reflection or GRAVITY flap physics,
// producing the sprite rectangle edges in screen coordinates.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int CW       = 12,
  parameter int VW       = 8,
  parameter int H_HALF   = 16,
  parameter int V_HALF   = 12,
  parameter int IX       = 160,
  parameter int IY       = 240,
  parameter int D_WIDTH  = 640,
  parameter int D_HEIGHT = 480,
  parameter int STEP_X   = 2,
  parameter int STEP_Y   = 2,
  parameter int GRAVITY  = 1,
  parameter int FLAP_V   = 8,
  parameter int VMAX     = 10
) (
  input logic           i_clk,
  input logic           i_rst,
  sprite_mover_if.slave bus
);
  localparam logic [CW-1:0]        IX_W     = IX[CW-1:0];
  localparam logic [CW-1:0]        IY_W     = IY[CW-1:0];
  localparam logic [CW-1:0]        HH_W     = H_HALF[CW-1:0];
  localparam logic [CW-1:0]        VH_W     = V_HALF[CW-1:0];
  localparam int                   NEG_FLAP = -FLAP_V;
  localparam logic signed [VW-1:0] FLAP_W   = NEG_FLAP[VW-1:0];
  localparam logic signed [VW:0]   GRAV_W   = GRAVITY[VW:0];
  localparam logic signed [VW:0]   VMAX_W   = VMAX[VW:0];

  sprite_state_t        state, state_n;
  logic [CW-1:0]        x, y, x_n, y_n;
  logic signed [VW-1:0] vy, vy_n;
  logic                 x_dir, y_dir, x_dir_n, y_dir_n;
  logic                 flap_pend, flap_n, mode_q, mode_n, bounce_q, bounce_n;

  logic [CW-1:0]        bx_pos, by_pos;
  logic                 bx_dir, by_dir, bx_hit, by_hit;

  axis_step #(.CW(CW), .HALF(H_HALF), .D_SIZE(D_WIDTH), .STEP(STEP_X)) u_axis_x (
    .pos(x), .dir(x_dir), .pos_n(bx_pos), .dir_n(bx_dir), .hit(bx_hit)
  );

  axis_step #(.CW(CW), .HALF(V_HALF), .D_SIZE(D_HEIGHT), .STEP(STEP_Y)) u_axis_y (
    .pos(y), .dir(y_dir), .pos_n(by_pos), .dir_n(by_dir), .hit(by_hit)
  );

  logic                 fp, upd, do_bounce, do_grav;
  logic signed [VW:0]   vy_inc;
  logic signed [VW-1:0] g_vy;
  logic signed [CW:0]   g_y;
  clamp_t               gc;

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    fp     = flap_pend | bus.i_flap;
    upd    = bus.i_ani_stb & bus.i_animate;
    vy_inc = {vy[VW-1], vy} + GRAV_W;
    if (fp)                  g_vy = FLAP_W;
    else if (vy_inc > VMAX_W) g_vy = VMAX_W[VW-1:0];
    else                     g_vy = vy_inc[VW-1:0];
    g_y = $signed({1'b0, y}) + (CW+1)'(g_vy);
    gc  = clamp_axis(32'(g_y), V_HALF, D_HEIGHT - 1 - V_HALF);

    state_n   = state;
    x_n       = x;
    y_n       = y;
    vy_n      = vy;
    x_dir_n   = x_dir;
    y_dir_n   = y_dir;
    flap_n    = fp;
    mode_n    = mode_q;
    bounce_n  = 1'b0;
    do_bounce = 1'b0;
    do_grav   = 1'b0;

    // The launching strobe out of IDLE is also the first motion update.
    case (state)
      IDLE: begin
        mode_n = bus.i_mode;
        if (upd && bus.i_mode == MODE_BOUNCE) do_bounce = 1'b1;
        else if (upd && fp)                   do_grav   = 1'b1;
      end
      RUN: begin
        if (upd) begin
          if (mode_q == MODE_BOUNCE) do_bounce = 1'b1;
          else                       do_grav   = 1'b1;
        end
      end
      default: ;
    endcase

    if (do_bounce) begin
      x_n      = bx_pos;
      y_n      = by_pos;
      x_dir_n  = bx_dir;
      y_dir_n  = by_dir;
      bounce_n = bx_hit | by_hit;
      state_n  = RUN;
      if (state == IDLE) flap_n = 1'b0;
    end

    if (do_grav) begin
      flap_n   = 1'b0;
      bounce_n = gc.hit_lo | gc.hit_hi;
      y_n      = CW'(gc.pos);
      vy_n     = bounce_n ? '0 : g_vy;
      state_n  = gc.hit_hi ? DEAD : RUN;
    end
  end

  // NOTE: registers use <= so every update reads the pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      x         <= IX_W;
      y         <= IY_W;
      vy        <= '0;
      x_dir     <= 1'b1;
      y_dir     <= 1'b1;
      flap_pend <= 1'b0;
      mode_q    <= MODE_BOUNCE;
      bounce_q  <= 1'b0;
    end else if (bus.i_restart) begin
      state     <= IDLE;
      x         <= IX_W;
      y         <= IY_W;
      vy        <= '0;
      x_dir     <= 1'b1;
      y_dir     <= 1'b1;
      flap_pend <= 1'b0;
      bounce_q  <= 1'b0;
    end else begin
      state     <= state_n;
      x         <= x_n;
      y         <= y_n;
      vy        <= vy_n;
      x_dir     <= x_dir_n;
      y_dir     <= y_dir_n;
      flap_pend <= flap_n;
      mode_q    <= mode_n;
      bounce_q  <= bounce_n;
    end
  end

  assign bus.o_x1     = x - HH_W;
  assign bus.o_x2     = x + HH_W;
  assign bus.o_y1     = y - VH_W;
  assign bus.o_y2     = y + VH_W;
  assign bus.o_state  = state;
  assign bus.o_bounce = bounce_q;
  assign bus.o_dead   = (state == DEAD);

endmodule
